// File: rtl/text_buffer.sv
// Character cell buffer for a text display: cursor-driven writes, scroll/clear walks,
// and a zero-latency read port for the pixel encoder.
module text_buffer #(
  parameter int unsigned ROWS       = 7,
  parameter int unsigned COLS       = 20,
  parameter logic [7:0]  BLANK_ID   = 8'd32,
  parameter int unsigned TOTAL_CHAR = 130
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [3:0] char_row,
  input  logic [5:0] char_col,
  output logic [7:0] character_id,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col
);
  localparam int unsigned CELLS        = ROWS * COLS;
  localparam int unsigned SCROLL_CELLS = (ROWS - 1) * COLS;
  localparam int unsigned AW           = 8;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_NL    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_SUB   = 8'h3F;

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL, BLANK_LAST} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] walk_q, walk_d;
  logic [3:0]    cursor_row_q, cursor_row_d;
  logic [5:0]    cursor_col_q, cursor_col_d;
  logic          char_ready_q, char_ready_d;

  logic [7:0]    mem_q [CELLS];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  logic [AW-1:0] cur_addr;
  logic [AW-1:0] rd_addr;
  logic          at_last_row;
  logic          at_last_col;

  assign cur_addr    = AW'(32'(cursor_row_q) * COLS + 32'(cursor_col_q));
  assign at_last_row = (32'(cursor_row_q) == ROWS - 1);
  assign at_last_col = (32'(cursor_col_q) == COLS - 1);

  // Pixel-encoder read port; off-screen coordinates see a blank cell
  always_comb begin
    rd_addr      = AW'(32'(char_row) * COLS + 32'(char_col));
    character_id = BLANK_ID;
    if ((32'(char_row) < ROWS) && (32'(char_col) < COLS)) begin
      character_id = mem_q[rd_addr];
    end
  end

  always_comb begin
    state_d      = state_q;
    walk_d       = walk_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    mem_we       = 1'b0;
    mem_waddr    = walk_q;
    mem_wdata    = BLANK_ID;

    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (32'(walk_q) == CELLS - 1) begin
          walk_d  = '0;
          state_d = IDLE;
        end else begin
          walk_d = walk_q + AW'(1);
        end
      end

      SCROLL: begin
        mem_we    = 1'b1;
        mem_wdata = mem_q[AW'(32'(walk_q) + COLS)];
        if (32'(walk_q) == SCROLL_CELLS - 1) begin
          walk_d  = '0;
          state_d = BLANK_LAST;
        end else begin
          walk_d = walk_q + AW'(1);
        end
      end

      BLANK_LAST: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(SCROLL_CELLS + 32'(walk_q));
        if (32'(walk_q) == COLS - 1) begin
          walk_d  = '0;
          state_d = IDLE;
        end else begin
          walk_d = walk_q + AW'(1);
        end
      end

      IDLE: begin
        if (char_valid) begin
          if (char_in == CH_FF) begin
            cursor_row_d = '0;
            cursor_col_d = '0;
            state_d      = CLEAR;
          end else if (char_in == CH_NL) begin
            cursor_col_d = '0;
            if (at_last_row) state_d = SCROLL;
            else cursor_row_d = cursor_row_q + 4'd1;
          end else if (char_in == CH_BS) begin
            // Backspace blanks the cell the cursor moves back onto
            if (cursor_col_q != '0) begin
              cursor_col_d = cursor_col_q - 6'd1;
              mem_we       = 1'b1;
            end else if (cursor_row_q != '0) begin
              cursor_row_d = cursor_row_q - 4'd1;
              cursor_col_d = 6'(COLS - 1);
              mem_we       = 1'b1;
            end
            mem_waddr = AW'(32'(cursor_row_d) * COLS + 32'(cursor_col_d));
          end else if (char_in >= CH_SPACE) begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdata = (32'(char_in) < TOTAL_CHAR) ? char_in : CH_SUB;
            if (!at_last_col) begin
              cursor_col_d = cursor_col_q + 6'd1;
            end else begin
              cursor_col_d = '0;
              if (at_last_row) state_d = SCROLL;
              else cursor_row_d = cursor_row_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = CLEAR;
        walk_d  = '0;
      end
    endcase

    char_ready_d = (state_d == IDLE);
  end

  // Cell storage is deliberately unreset; CLEAR blanks it after reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      walk_q       <= '0;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      char_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      char_ready_q <= char_ready_d;
    end
  end

  assign char_ready = char_ready_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;

endmodule

// File: tb/tb_text_buffer.sv
// Directed and randomised bench for text_buffer, checked every cycle against a
// cell-array model of the screen (cursor, contents, busy time).
module tb_text_buffer;
  localparam int R    = 7;
  localparam int C    = 20;
  localparam int N    = R * C;
  localparam int BUSY = 140;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [3:0] char_row;
  logic [5:0] char_col;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;

  text_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_row     (char_row),
    .char_col     (char_col),
    .character_id (character_id),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col)
  );

  always #5 clk = ~clk;

  // Screen model: what the display must show once the block is idle
  int m_cell [N];
  int m_row, m_col, m_busy;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_read(input int r, input int c);
    return (r < R && c < C) ? m_cell[r*C + c] : 32;
  endfunction

  task automatic model_blank_all();
    for (int i = 0; i < N; i++) m_cell[i] = 32;
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_busy = BUSY;
    model_blank_all();
  endtask

  task automatic model_scroll();
    for (int i = 0; i < N - C; i++) m_cell[i] = m_cell[i + C];
    for (int i = N - C; i < N; i++) m_cell[i] = 32;
    m_row = R - 1; m_col = 0; m_busy = BUSY;
  endtask

  task automatic model_accept(input int c);
    if (c == 12) begin
      m_row = 0; m_col = 0; m_busy = BUSY;
      model_blank_all();
    end else if (c == 13) begin
      if (m_row < R - 1) begin m_row++; m_col = 0; end
      else model_scroll();
    end else if (c == 8) begin
      if (m_col > 0) begin m_col--; m_cell[m_row*C + m_col] = 32; end
      else if (m_row > 0) begin m_row--; m_col = C - 1; m_cell[m_row*C + m_col] = 32; end
    end else if (c >= 32) begin
      m_cell[m_row*C + m_col] = (c < 130) ? c : 63;
      if (m_col < C - 1) m_col++;
      else if (m_row < R - 1) begin m_row++; m_col = 0; end
      else model_scroll();
    end
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (m_busy > 0) m_busy--;
    else if (char_valid) model_accept(int'(char_in));
  endtask

  task automatic compare();
    int exp_ready;
    exp_ready = (rst_n && m_busy == 0) ? 1 : 0;
    chk("char_ready", int'(char_ready), exp_ready);
    chk("cursor_row", int'(cursor_row), m_row);
    chk("cursor_col", int'(cursor_col), m_col);
    if (exp_ready == 1)
      chk("character_id", int'(character_id), m_read(int'(char_row), int'(char_col)));
  endtask

  // One clock cycle: drive, step the model on the edge, compare on the falling edge
  task automatic cyc(input logic v, input logic [7:0] c);
    char_valid = v;
    char_in    = c;
    char_row   = 4'($urandom_range(0, 8));
    char_col   = 6'($urandom_range(0, 22));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!char_ready && n < 1000) begin
      cyc(1'b0, 8'h00);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", int'(char_ready), 1);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    wait_ready(n);
    cyc(1'b1, c);
  endtask

  task automatic peek(input int r, input int c, input int exp, input string name);
    char_valid = 1'b0;
    char_row   = 4'(r);
    char_col   = 6'(c);
    #1;
    chk(name, int'(character_id), exp);
  endtask

  initial begin
    int n;
    int k;
    logic [7:0] code;

    rst_n = 1'b0; char_valid = 1'b0; char_in = '0; char_row = '0; char_col = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", int'(char_ready), 0);
    chk("reset_row", int'(cursor_row), 0);
    chk("reset_col", int'(cursor_col), 0);

    // Power-up clear
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("clear_busy_cycles", n, 140);
    chk("ready_after_clear", int'(char_ready), 1);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) peek(r, c, 32, $sformatf("blank_r%0d_c%0d", r, c));
    peek(7, 0, 32, "offscreen_row7");
    peek(2, 20, 32, "offscreen_col20");

    // "HI"
    send(8'h48); send(8'h49); cyc(1'b0, 8'h00);
    peek(0, 0, 8'h48, "hi_cell00");
    peek(0, 1, 8'h49, "hi_cell01");
    chk("hi_cursor_row", int'(cursor_row), 0);
    chk("hi_cursor_col", int'(cursor_col), 2);

    // Backspace, including the no-op at the origin
    send(8'h0C); send(8'h41); send(8'h08); send(8'h08); cyc(1'b0, 8'h00);
    peek(0, 0, 32, "bs_cell00");
    chk("bs_cursor_row", int'(cursor_row), 0);
    chk("bs_cursor_col", int'(cursor_col), 0);

    // Fill the screen to force a scroll
    for (int i = 0; i < N; i++) send(8'(32'h41 + i / C));
    chk("fill_cursor_row", int'(cursor_row), 6);
    chk("fill_cursor_col", int'(cursor_col), 0);
    chk("fill_ready_low", int'(char_ready), 0);
    wait_ready(n);
    chk("scroll_busy_cycles", n, 140);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        peek(r, c, (r < R - 1) ? 32'h42 + r : 32, $sformatf("scrolled_r%0d_c%0d", r, c));

    // Newline without scroll, substitution glyph, backspace across a row
    send(8'h0C); send(8'h0D); send(8'h0D); send(8'h0D);
    chk("nl_row3", int'(cursor_row), 3);
    send(8'h0D);
    chk("nl_row4", int'(cursor_row), 4);
    chk("nl_col0", int'(cursor_col), 0);
    cyc(1'b0, 8'h00);
    chk("nl_no_scroll", int'(char_ready), 1);
    send(8'hFF); cyc(1'b0, 8'h00);
    peek(4, 0, 8'h3F, "sub_glyph_cell40");
    chk("sub_cursor_col", int'(cursor_col), 1);
    send(8'h08); send(8'h08);
    chk("bs_wrap_row", int'(cursor_row), 3);
    chk("bs_wrap_col", int'(cursor_col), 19);

    // Reset in the middle of a scroll
    send(8'h0D); send(8'h0D); send(8'h0D); send(8'h0D);
    chk("scroll_start_ready", int'(char_ready), 0);
    repeat (50) cyc(1'b0, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_ready", int'(char_ready), 0);
    chk("abort_row", int'(cursor_row), 0);
    chk("abort_col", int'(cursor_col), 0);
    repeat (2) cyc(1'b0, 8'h00);
    rst_n = 1'b1;
    wait_ready(n);
    chk("abort_clear_cycles", n, 140);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) peek(r, c, 32, $sformatf("abort_blank_r%0d_c%0d", r, c));

    // Random character stream with valid held/dropped at random
    repeat (6000) begin
      k = int'($urandom_range(0, 99));
      if (k < 55)      code = 8'($urandom_range(32'h20, 32'h81));
      else if (k < 65) code = 8'($urandom_range(32'h82, 32'hFF));
      else if (k < 78) code = 8'h0D;
      else if (k < 90) code = 8'h08;
      else if (k < 91) code = 8'h0C;
      else             code = 8'($urandom_range(0, 31));
      cyc(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, code);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
